// File: rtl/mem_bank_access_sched_pkg.sv
// Shared types and default sizing for the memory bank access scheduler.
// The package constants size the write-request struct; the top parameters default to them.
package mem_sched_pkg;

  localparam int MS_DATA_WIDTH = 16;
  localparam int MS_DEPTH      = 18;
  localparam int MS_NUM_BANKS  = 2;
  localparam int MS_AW         = (MS_DEPTH > 1) ? $clog2(MS_DEPTH) : 1;
  localparam int MS_BW         = (MS_NUM_BANKS > 1) ? $clog2(MS_NUM_BANKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [MS_BW-1:0]         bank;
    logic [MS_AW-1:0]         addr;
    logic [MS_DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/mem_bank_access_sched_if.sv
// Writeback, host-write, memory-port and read-tag bundle of the scheduler.
// Handshake: host write transfers on a cycle where host_valid & host_ready; writeback has no ready.
interface mem_bank_access_sched_if
  import mem_sched_pkg::*;
#(
  parameter int DW = MS_DATA_WIDTH,
  parameter int AW = MS_AW,
  parameter int BW = MS_BW
) ();

  logic          wb_valid;
  logic [BW-1:0] wb_bank;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  logic          host_valid;
  logic          host_ready;
  logic [BW-1:0] host_bank;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;

  logic          mem_wea;
  logic [BW-1:0] mem_banka;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dia;

  logic          mem_reb;
  logic [BW-1:0] mem_bankb;
  logic [AW-1:0] mem_addrb;

  logic          rd_valid;
  logic [BW-1:0] rd_bank;
  logic [AW-1:0] rd_addr;

  modport slave (
    input  wb_valid, wb_bank, wb_addr, wb_data,
    input  host_valid, host_bank, host_addr, host_data,
    output host_ready,
    output mem_wea, mem_banka, mem_addra, mem_dia,
    output mem_reb, mem_bankb, mem_addrb,
    output rd_valid, rd_bank, rd_addr
  );

  modport master (
    output wb_valid, wb_bank, wb_addr, wb_data,
    output host_valid, host_bank, host_addr, host_data,
    input  host_ready,
    input  mem_wea, mem_banka, mem_addra, mem_dia,
    input  mem_reb, mem_bankb, mem_addrb,
    input  rd_valid, rd_bank, rd_addr
  );

endinterface

// File: rtl/mem_bank_access_sched_pipeline_sr.sv
// pipeline_sr: resettable shift register of STAGES stages; STAGES = 0 is a wire.
module pipeline_sr #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [STAGES];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
    end
    assign dout = sr[STAGES-1];
  end

endmodule

// File: rtl/mem_bank_access_sched.sv
// Owns the memory write port (writeback over host) and sweeps every (bank, addr) on sample_start.
// Optional MEM_SCHED_STATS_EN adds saturating host-stall and overrun counters.
module mem_bank_access_sched
  import mem_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = MS_DATA_WIDTH,
  parameter int DEPTH        = MS_DEPTH,
  parameter int NUM_BANKS    = MS_NUM_BANKS,
  parameter int OUTPUT_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_start,
  output logic        sweep_busy,
  output logic        sweep_done,
  output logic        sweep_overrun,
  output logic [1:0]  state_dbg,
`ifdef MEM_SCHED_STATS_EN
  output logic [15:0] host_stall_cnt,
  output logic [7:0]  overrun_cnt,
`endif
  mem_bank_access_sched_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] SWEEP = 2'(ST_SWEEP);
  localparam logic [1:0] DRAIN = 2'(ST_DRAIN);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BANK  = BW'(NUM_BANKS - 1);
  localparam int            DCW        = (OUTPUT_DELAY > 1) ? $clog2(OUTPUT_DELAY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((OUTPUT_DELAY > 0) ? OUTPUT_DELAY - 1 : 0);

  logic [1:0]     state;
  logic [DCW-1:0] drain_cnt;
  logic           last_issue;
  wr_req_t        wr_req;

  // Writeback wins; the host only transfers when it sees ready.
  assign bus.host_ready = !bus.wb_valid;

  always_comb begin
    wr_req = '{bank: bus.host_bank, addr: bus.host_addr, data: bus.host_data};
    if (bus.wb_valid) wr_req = '{bank: bus.wb_bank, addr: bus.wb_addr, data: bus.wb_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_wea   <= 1'b0;
      bus.mem_banka <= '0;
      bus.mem_addra <= '0;
      bus.mem_dia   <= '0;
    end else begin
      bus.mem_wea <= bus.wb_valid | bus.host_valid;
      if (bus.wb_valid | bus.host_valid) begin
        bus.mem_banka <= wr_req.bank;
        bus.mem_addra <= wr_req.addr;
        bus.mem_dia   <= wr_req.data;
      end
    end
  end

  // The registered read port doubles as the sweep counter.
  assign last_issue = (bus.mem_bankb == LAST_BANK) && (bus.mem_addrb == LAST_ADDR);
  assign sweep_busy = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      bus.mem_reb   <= 1'b0;
      bus.mem_bankb <= '0;
      bus.mem_addrb <= '0;
      sweep_done    <= 1'b0;
      sweep_overrun <= 1'b0;
    end else begin
      sweep_done    <= 1'b0;
      sweep_overrun <= sample_start && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_start) begin
            state         <= SWEEP;
            bus.mem_reb   <= 1'b1;
            bus.mem_bankb <= '0;
            bus.mem_addrb <= '0;
          end
        end
        SWEEP: begin
          if (last_issue) begin
            bus.mem_reb   <= 1'b0;
            bus.mem_bankb <= '0;
            bus.mem_addrb <= '0;
            drain_cnt     <= '0;
            if (OUTPUT_DELAY == 0) begin
              state      <= IDLE;
              sweep_done <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (bus.mem_addrb == LAST_ADDR) begin
            bus.mem_bankb <= bus.mem_bankb + BW'(1);
            bus.mem_addrb <= '0;
          end else begin
            bus.mem_addrb <= bus.mem_addrb + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state      <= IDLE;
            sweep_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag follows the read port by the memory's read latency.
  pipeline_sr #(
    .WIDTH  (1 + BW + AW),
    .STAGES (OUTPUT_DELAY)
  ) u_tag_sr (
    .clk   (clk),
    .reset (reset),
    .din   ({bus.mem_reb, bus.mem_bankb, bus.mem_addrb}),
    .dout  ({bus.rd_valid, bus.rd_bank, bus.rd_addr})
  );

`ifdef MEM_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      host_stall_cnt <= '0;
      overrun_cnt    <= '0;
    end else begin
      if (bus.host_valid && !bus.host_ready && (host_stall_cnt != 16'hFFFF))
        host_stall_cnt <= host_stall_cnt + 16'd1;
      if (sweep_overrun && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
